// File: rtl/cpc_ppi_pkg.sv
// Shared types and constants for the CPC 8255 PPI bus arbiter.
package cpc_ppi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StZAcc,
        StZCap,
        StZHold,
        StSAcc,
        StSCap
    } arb_state_e;

    localparam logic [1:0] PPI_PORT_A    = 2'd0;
    localparam logic [1:0] PPI_PORT_B    = 2'd1;
    localparam logic [1:0] PPI_PORT_C    = 2'd2;
    localparam logic [1:0] PPI_CTRL      = 2'd3;
    localparam logic [7:0] PPI_IDLE_DATA = 8'hff;

endpackage

// File: rtl/ppi_strobe_gen.sv
// Timed nCS/nRD/nWR window generator for one PPI access; all pins registered.
module ppi_strobe_gen
    import cpc_ppi_pkg::*;
#(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       last,
    output logic       done,
    output logic       ncs,
    output logic [1:0] a,
    output logic       nrd,
    output logic       nwr,
    output logic [7:0] d
);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            done     <= 1'b0;
            ncs      <= 1'b1;
            nrd      <= 1'b1;
            nwr      <= 1'b1;
            a        <= PPI_PORT_A;
            d        <= PPI_IDLE_DATA;
        end else begin
            done <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                cnt_q    <= CNT_W'(STROBE_CYC - 1);
                ncs      <= 1'b0;
                nrd      <= we;
                nwr      <= !we;
                a        <= addr;
                d        <= wdata;
            end else if (active_q) begin
                if (cnt_q == '0) begin
                    // Close the window; address and data stay put for the capture cycle.
                    active_q <= 1'b0;
                    ncs      <= 1'b1;
                    nrd      <= 1'b1;
                    nwr      <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign last = active_q && (cnt_q == '0);

endmodule

// File: rtl/ppi_bus_arbiter.sv
// Arbitrates the 8255 PPI register interface between the Z80 I/O bus (priority)
// and the supervisor req/ack port.
module ppi_bus_arbiter
    import cpc_ppi_pkg::*;
#(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       z_ncs_i,
    input  logic [1:0] z_a_i,
    input  logic       z_nrd_i,
    input  logic       z_nwr_i,
    input  logic [7:0] z_d_i,
    output logic [7:0] z_d_o,
    output logic       z_wait_o,
    input  logic       s_req_i,
    input  logic       s_we_i,
    input  logic [1:0] s_addr_i,
    input  logic [7:0] s_d_i,
    output logic [7:0] s_d_o,
    output logic       s_ack_o,
    output logic       ppi_ncs_o,
    output logic [1:0] ppi_a_o,
    output logic       ppi_nrd_o,
    output logic       ppi_nwr_o,
    output logic [7:0] ppi_d_o,
    input  logic [7:0] ppi_d_i
);

    arb_state_e state_q, state_d;
    logic       start_q, start_d;
    logic       we_q, we_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wait_q, wait_d;
    logic [7:0] z_rdata_q, z_rdata_d;
    logic [7:0] s_rdata_q, s_rdata_d;
    logic       ack_q, ack_d;
    logic       z_req;
    logic       strobe_last;
    logic       strobe_done;

    assign z_req = !z_ncs_i && (!z_nrd_i || !z_nwr_i);

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        z_rdata_d = z_rdata_q;
        s_rdata_d = s_rdata_q;
        ack_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                wait_d = 1'b0;
                if (z_req) begin
                    state_d = StZAcc;
                    start_d = 1'b1;
                    we_d    = !z_nwr_i;
                    addr_d  = z_a_i;
                    wdata_d = z_d_i;
                    wait_d  = 1'b1;
                end else if (s_req_i) begin
                    state_d = StSAcc;
                    start_d = 1'b1;
                    we_d    = s_we_i;
                    addr_d  = s_addr_i;
                    wdata_d = s_d_i;
                end
            end
            StZAcc: begin
                if (strobe_last) state_d = StZCap;
            end
            StZCap: begin
                if (strobe_done) begin
                    if (!we_q) z_rdata_d = ppi_d_i;
                    wait_d  = 1'b0;
                    state_d = StZHold;
                end
            end
            StZHold: begin
                // Wait for the Z80 cycle to end so one bus cycle maps to one access.
                if (z_ncs_i || (z_nrd_i && z_nwr_i)) state_d = StIdle;
            end
            StSAcc: begin
                wait_d = z_req;
                if (strobe_last) state_d = StSCap;
            end
            StSCap: begin
                wait_d = z_req;
                if (strobe_done) begin
                    if (!we_q) s_rdata_d = ppi_d_i;
                    ack_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= PPI_PORT_A;
            wdata_q   <= PPI_IDLE_DATA;
            wait_q    <= 1'b0;
            z_rdata_q <= PPI_IDLE_DATA;
            s_rdata_q <= PPI_IDLE_DATA;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            z_rdata_q <= z_rdata_d;
            s_rdata_q <= s_rdata_d;
            ack_q     <= ack_d;
        end
    end

    ppi_strobe_gen #(
        .STROBE_CYC(STROBE_CYC),
        .CNT_W     (CNT_W)
    ) u_strobe_gen (
        .clk   (clk_i),
        .nreset(nreset_i),
        .start (start_q),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .last  (strobe_last),
        .done  (strobe_done),
        .ncs   (ppi_ncs_o),
        .a     (ppi_a_o),
        .nrd   (ppi_nrd_o),
        .nwr   (ppi_nwr_o),
        .d     (ppi_d_o)
    );

    assign z_d_o    = z_rdata_q;
    assign z_wait_o = wait_q;
    assign s_d_o    = s_rdata_q;
    assign s_ack_o  = ack_q;

endmodule

// File: tb/tb_ppi_bus_arbiter.sv
// Randomised and directed bench for ppi_bus_arbiter against a transaction-level model.
module tb_ppi_bus_arbiter;
    import cpc_ppi_pkg::*;

    localparam int unsigned S  = 2;
    localparam int unsigned S1 = 1;

    typedef struct {
        logic [1:0] a;
        logic       we;
        logic [7:0] d;
        int         len;
        int         start;
    } access_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nreset;
    logic       z_ncs, z_nrd, z_nwr, z_wait;
    logic [1:0] z_a;
    logic [7:0] z_d, z_q;
    logic       s_req, s_we, s_ack;
    logic [1:0] s_addr;
    logic [7:0] s_d, s_q;
    logic       ppi_ncs, ppi_nrd, ppi_nwr;
    logic [1:0] ppi_a;
    logic [7:0] ppi_do, ppi_di;

    logic       s1_req, s1_we, s1_ack, s1_zwait;
    logic [1:0] s1_addr, s1_a;
    logic [7:0] s1_d, s1_q, s1_zq, s1_pdo, s1_ppi_di;
    logic       s1_ncs, s1_nrd, s1_nwr;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int bad_strobe = 0;
    int unstable = 0;
    logic in_win = 1'b0;
    access_t cur;
    access_t obs_q[$];

    ppi_bus_arbiter #(.STROBE_CYC(S), .CNT_W(4)) u_dut (
        .clk_i(clk), .nreset_i(nreset),
        .z_ncs_i(z_ncs), .z_a_i(z_a), .z_nrd_i(z_nrd), .z_nwr_i(z_nwr), .z_d_i(z_d),
        .z_d_o(z_q), .z_wait_o(z_wait),
        .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_d_i(s_d),
        .s_d_o(s_q), .s_ack_o(s_ack),
        .ppi_ncs_o(ppi_ncs), .ppi_a_o(ppi_a), .ppi_nrd_o(ppi_nrd), .ppi_nwr_o(ppi_nwr),
        .ppi_d_o(ppi_do), .ppi_d_i(ppi_di)
    );

    ppi_bus_arbiter #(.STROBE_CYC(S1), .CNT_W(4)) u_dut_s1 (
        .clk_i(clk), .nreset_i(nreset),
        .z_ncs_i(1'b1), .z_a_i(2'd0), .z_nrd_i(1'b1), .z_nwr_i(1'b1), .z_d_i(8'h00),
        .z_d_o(s1_zq), .z_wait_o(s1_zwait),
        .s_req_i(s1_req), .s_we_i(s1_we), .s_addr_i(s1_addr), .s_d_i(s1_d),
        .s_d_o(s1_q), .s_ack_o(s1_ack),
        .ppi_ncs_o(s1_ncs), .ppi_a_o(s1_a), .ppi_nrd_o(s1_nrd), .ppi_nwr_o(s1_nwr),
        .ppi_d_o(s1_pdo), .ppi_d_i(s1_ppi_di)
    );

    // Record every nCS window seen on the PPI pins as one access.
    always @(negedge clk) begin
        cyc++;
        if (s_ack) ack_cnt++;
        if (!ppi_ncs) begin
            if (ppi_nrd == ppi_nwr) bad_strobe++;
            if (!in_win) begin
                in_win    = 1'b1;
                cur.a     = ppi_a;
                cur.we    = !ppi_nwr;
                cur.d     = ppi_do;
                cur.len   = 0;
                cur.start = cyc;
            end else if (cur.a != ppi_a || cur.d != ppi_do || cur.we != !ppi_nwr) begin
                unstable++;
            end
            cur.len++;
        end else if (in_win) begin
            in_win = 1'b0;
            obs_q.push_back(cur);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_access(input string tag, input logic we, input logic [1:0] a,
                                 input logic [7:0] d);
        access_t acc;
        check({tag, "_present"}, 32'(obs_q.size() > 0), 1);
        if (obs_q.size() > 0) begin
            acc = obs_q.pop_front();
            check({tag, "_we"}, 32'(acc.we), 32'(we));
            check({tag, "_addr"}, 32'(acc.a), 32'(a));
            check({tag, "_data"}, 32'(acc.d), 32'(d));
            check({tag, "_len"}, acc.len, S);
        end
    endtask

    // mode: 0 read, 1 write, 2 both strobes low (a write).
    task automatic z_access(input int mode, input logic [1:0] a, input logic [7:0] d,
                            input logic [7:0] pd, input int hold);
        int n;
        logic we;
        we = (mode != 0);
        ppi_di = pd;
        z_a = a;
        z_d = d;
        z_nrd = (mode == 1);
        z_nwr = (mode == 0);
        z_ncs = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("z_wait_rise", 32'(z_wait), 1);
        end while (z_wait && n < 40);
        check("z_latency", n - 1, S + 2);
        if (!we) check("z_rdata", 32'(z_q), 32'(pd));
        repeat (hold) @(negedge clk);
        z_ncs = 1'b1;
        z_nrd = 1'b1;
        z_nwr = 1'b1;
        repeat (S + 4) @(negedge clk);
        expect_access("z_acc", we, a, d);
        check("z_single_access", obs_q.size(), 0);
    endtask

    task automatic s_access(input logic we, input logic [1:0] a, input logic [7:0] d,
                            input logic [7:0] pd);
        int n;
        int acks;
        ppi_di = pd;
        s_we = we;
        s_addr = a;
        s_d = d;
        s_req = 1'b1;
        acks = ack_cnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ack && n < 40);
        s_req = 1'b0;
        check("s_latency", n - 1, S + 2);
        if (!we) check("s_rdata", 32'(s_q), 32'(pd));
        @(negedge clk);
        check("s_ack_once", ack_cnt - acks, 1);
        @(negedge clk);
        expect_access("s_acc", we, a, d);
    endtask

    task automatic s1_access(input logic we, input logic [1:0] a, input logic [7:0] d,
                             input logic [7:0] pd);
        int n;
        int low;
        s1_ppi_di = pd;
        s1_we = we;
        s1_addr = a;
        s1_d = d;
        s1_req = 1'b1;
        n = 0;
        low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!s1_ncs) begin
                low++;
                check("s1_strobe_dir", 32'(we ? s1_nrd && !s1_nwr : !s1_nrd && s1_nwr), 1);
                check("s1_addr", 32'(s1_a), 32'(a));
                check("s1_pdata", 32'(s1_pdo), 32'(d));
            end
        end while (!s1_ack && n < 40);
        s1_req = 1'b0;
        check("s1_latency", n - 1, S1 + 2);
        check("s1_low_cycles", low, S1);
        if (!we) check("s1_rdata", 32'(s1_q), 32'(pd));
        check("s1_no_zwait", 32'(s1_zwait), 0);
        check("s1_zdata_idle", 32'(s1_zq), 32'(PPI_IDLE_DATA));
        @(negedge clk);
        check("s1_ack_pulse", 32'(s1_ack), 0);
    endtask

    initial begin
        int n;
        int m;
        int acks;
        int rel;
        logic [7:0] zd;
        access_t a0;
        access_t a1;

        nreset = 1'b0;
        z_ncs = 1'b1; z_nrd = 1'b1; z_nwr = 1'b1; z_a = 2'd0; z_d = 8'h00;
        s_req = 1'b0; s_we = 1'b0; s_addr = 2'd0; s_d = 8'h00; ppi_di = 8'h00;
        s1_req = 1'b0; s1_we = 1'b0; s1_addr = 2'd0; s1_d = 8'h00; s1_ppi_di = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ncs", 32'(ppi_ncs), 1);
        check("rst_nrd", 32'(ppi_nrd), 1);
        check("rst_nwr", 32'(ppi_nwr), 1);
        check("rst_addr", 32'(ppi_a), 0);
        check("rst_pdata", 32'(ppi_do), 32'(PPI_IDLE_DATA));
        check("rst_zdata", 32'(z_q), 32'(PPI_IDLE_DATA));
        check("rst_sdata", 32'(s_q), 32'(PPI_IDLE_DATA));
        check("rst_wait", 32'(z_wait), 0);
        check("rst_ack", 32'(s_ack), 0);
        nreset = 1'b1;
        @(negedge clk);

        // Z80 read of port B with a long bus cycle, then supervisor write of port C.
        z_access(0, PPI_PORT_B, 8'h00, 8'h5a, 6);
        s_access(1'b1, PPI_PORT_C, 8'h3c, 8'h00);

        // Same-cycle requests: the Z80 write goes first, supervisor read after Z_HOLD.
        z_a = PPI_PORT_A; z_d = 8'h11; z_nrd = 1'b1; z_nwr = 1'b0; z_ncs = 1'b0;
        s_we = 1'b0; s_addr = PPI_PORT_A; s_d = 8'h00; s_req = 1'b1; ppi_di = 8'h22;
        acks = ack_cnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (z_wait && n < 40);
        check("sim_z_latency", n - 1, S + 2);
        repeat (2) @(negedge clk);
        rel = cyc;
        z_ncs = 1'b1; z_nwr = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ack && n < 40);
        s_req = 1'b0;
        check("sim_s_rdata", 32'(s_q), 32'h22);
        repeat (2) @(negedge clk);
        check("sim_s_ack_once", ack_cnt - acks, 1);
        expect_access("sim_z", 1'b1, PPI_PORT_A, 8'h11);
        if (obs_q.size() > 0) check("sim_s_after_hold", 32'(obs_q[0].start > rel + 1), 1);
        expect_access("sim_s", 1'b0, PPI_PORT_A, 8'h00);

        // Z80 read of the control port arrives one cycle into a supervisor write.
        s_we = 1'b1; s_addr = PPI_PORT_C; s_d = 8'h3c; s_req = 1'b1; ppi_di = 8'h99;
        zd = 8'h47;
        repeat (2) @(negedge clk);
        z_a = PPI_CTRL; z_d = zd; z_nrd = 1'b0; z_nwr = 1'b1; z_ncs = 1'b0;
        @(negedge clk);
        check("zs_wait_rise", 32'(z_wait), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ack && n < 40);
        s_req = 1'b0;
        check("zs_s_latency", n + 2, S + 2);
        check("zs_wait_held", 32'(z_wait), 1);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (z_wait && m < 40);
        check("zs_z_latency", m, S + 3);
        check("zs_z_rdata", 32'(z_q), 32'h99);
        z_ncs = 1'b1; z_nrd = 1'b1;
        repeat (S + 4) @(negedge clk);
        if (obs_q.size() > 1) begin
            a0 = obs_q[0];
            a1 = obs_q[1];
            check("zs_no_overlap", 32'(a1.start > a0.start + a0.len), 1);
        end
        expect_access("zs_s", 1'b1, PPI_PORT_C, 8'h3c);
        expect_access("zs_z", 1'b0, PPI_CTRL, zd);

        // Random mix of sequential accesses.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                z_access(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                         8'($urandom), 8'($urandom), int'($urandom_range(0, 8)));
            else
                s_access(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a supervisor access.
        acks = ack_cnt;
        s_we = 1'b0; s_addr = PPI_PORT_B; s_req = 1'b1; ppi_di = 8'h77;
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_ncs", 32'(ppi_ncs), 1);
            check("mid_rst_strobes", 32'(ppi_nrd && ppi_nwr), 1);
            check("mid_rst_zdata", 32'(z_q), 32'(PPI_IDLE_DATA));
        end
        s_req = 1'b0;
        nreset = 1'b1;
        repeat (S + 4) @(negedge clk);
        check("mid_rst_no_ack", ack_cnt - acks, 0);
        check("mid_rst_sdata", 32'(s_q), 32'(PPI_IDLE_DATA));
        check("mid_rst_idle", 32'(ppi_ncs), 1);
        obs_q.delete();

        // Single-cycle strobe instance.
        s1_access(1'b0, PPI_PORT_A, 8'h00, 8'ha5);
        for (int i = 0; i < 6; i++) begin
            s1_access(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("strobe_exclusive", bad_strobe, 0);
        check("window_stable", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
